// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter bus bundle: ALU/LSU requests, register file write port, hazard lookup
interface regfile_wb_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;

    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;

    logic [ADDR_W-1:0] chk_reg;
    logic              chk_pending;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output chk_reg,
        input  alu_ready, lsu_ready,
        input  rf_reg_write, rf_write_reg, rf_write_data,
        input  chk_pending, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  chk_reg,
        output alu_ready, lsu_ready,
        output rf_reg_write, rf_write_reg, rf_write_data,
        output chk_pending, fifo_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between ALU and buffered LSU writeback
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t            state;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_nxt;

    logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              alu_grant;
    logic              any_grant;
    logic [ADDR_W-1:0] grant_rd;
    logic [DATA_W-1:0] grant_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_reg;
    logic [DATA_W-1:0] rf_data;

    logic [FIFO_DEPTH-1:0] ent_hit;

    assign fifo_empty    = (count == '0);
    assign bus.lsu_ready = reset_n && (count < CNT_W'(FIFO_DEPTH));
    assign bus.alu_ready = reset_n && (state == ST_NORMAL);

    assign push      = bus.lsu_valid && bus.lsu_ready;
    assign alu_grant = bus.alu_valid && bus.alu_ready;
    // The head is served whenever the ALU does not take the slot; in FORCE alu_ready is low.
    assign pop       = !fifo_empty && !alu_grant;
    assign any_grant = alu_grant || pop;

    assign grant_rd   = alu_grant ? bus.alu_rd   : fifo_rd[rd_ptr];
    assign grant_data = alu_grant ? bus.alu_data : fifo_data[rd_ptr];

    always_comb begin
        starve_nxt = starve_cnt;
        if (fifo_empty || pop) begin
            starve_nxt = '0;
        end else if (starve_cnt < SC_W'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]   <= bus.lsu_rd;
                fifo_data[wr_ptr] <= bus.lsu_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Arbitration state, starvation tracking and the registered write stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_reg     <= '0;
            rf_data    <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            case (state)
                ST_NORMAL: begin
                    if (starve_nxt == SC_W'(STARVE_LIMIT)) begin
                        state <= ST_FORCE;
                    end
                end
                ST_FORCE: begin
                    if (pop || fifo_empty) begin
                        state <= ST_NORMAL;
                    end
                end
                default: state <= ST_NORMAL;
            endcase
            rf_we <= any_grant && (grant_rd != '0);
            if (any_grant) begin
                rf_reg  <= grant_rd;
                rf_data <= grant_data;
            end
        end
    end

    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_hit
        logic [PTR_W-1:0] off;
        assign off        = PTR_W'(g) - rd_ptr;
        assign ent_hit[g] = ({1'b0, off} < count) && (fifo_rd[g] == bus.chk_reg);
    end

    assign bus.chk_pending   = (bus.chk_reg != '0) &&
                               ((|ent_hit) || (rf_we && (rf_reg == bus.chk_reg)));
    assign bus.fifo_count    = count;
    assign bus.rf_reg_write  = rf_we;
    assign bus.rf_write_reg  = rf_reg;
    assign bus.rf_write_data = rf_data;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and random checks of regfile_wb_arbiter against a queue-based model
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } beat_t;

    beat_t       q[$];
    int          waited;
    bit          forced;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        waited = 0;
        forced = 0;
        m_we   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    task automatic check_outputs();
        bit pend;
        pend = 0;
        foreach (q[i]) if (q[i].rd == bus.chk_reg) pend = 1;
        if (m_we && m_reg == bus.chk_reg) pend = 1;
        if (bus.chk_reg == 5'd0) pend = 0;
        chk("alu_ready",   64'(bus.alu_ready),     64'(!forced));
        chk("lsu_ready",   64'(bus.lsu_ready),     64'(q.size() < DEPTH));
        chk("fifo_count",  64'(bus.fifo_count),    64'(q.size()));
        chk("rf_we",       64'(bus.rf_reg_write),  64'(m_we));
        chk("rf_reg",      64'(bus.rf_write_reg),  64'(m_reg));
        chk("rf_data",     64'(bus.rf_write_data), 64'(m_data));
        chk("chk_pending", 64'(bus.chk_pending),   64'(pend));
    endtask

    task automatic model_tick();
        beat_t b;
        bit    granted;
        bit    popped;
        int    occ;
        occ     = q.size();
        granted = 0;
        popped  = 0;
        b       = '0;
        if (bus.alu_valid && !forced) begin
            b.rd    = bus.alu_rd;
            b.data  = bus.alu_data;
            granted = 1;
        end else if (occ > 0) begin
            b       = q.pop_front();
            granted = 1;
            popped  = 1;
        end
        if (popped) begin
            waited = 0;
            forced = 0;
        end else if (occ == 0) begin
            waited = 0;
        end else begin
            if (waited < LIMIT) waited++;
            if (waited == LIMIT) forced = 1;
        end
        m_we = granted && (b.rd != 5'd0);
        if (granted) begin
            m_reg  = b.rd;
            m_data = b.data;
        end
        if (bus.lsu_valid && occ < DEPTH) q.push_back({bus.lsu_rd, bus.lsu_data});
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset_n       = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
        bus.chk_reg   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",    64'(bus.rf_reg_write),  64'(0));
        chk("rst_reg",   64'(bus.rf_write_reg),  64'(0));
        chk("rst_data",  64'(bus.rf_write_data), 64'(0));
        chk("rst_count", 64'(bus.fifo_count),    64'(0));
        chk("rst_pend",  64'(bus.chk_pending),   64'(0));
        chk("rst_alu_r", 64'(bus.alu_ready),     64'(0));
        chk("rst_lsu_r", 64'(bus.lsu_ready),     64'(0));
        reset_n = 1'b1;

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        step();
        bus.alu_valid = 1'b0;
        chk("t1_we",   64'(bus.rf_reg_write),  64'(1));
        chk("t1_reg",  64'(bus.rf_write_reg),  64'(5));
        chk("t1_data", 64'(bus.rf_write_data), 64'(32'hDEADBEEF));
        step();
        chk("t1_idle", 64'(bus.rf_reg_write),  64'(0));

        // simultaneous ALU and LSU
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3333;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h7777;
        step();
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        chk("t2_reg_alu", 64'(bus.rf_write_reg), 64'(3));
        chk("t2_cnt1",    64'(bus.fifo_count),   64'(1));
        step();
        chk("t2_reg_lsu", 64'(bus.rf_write_reg),  64'(7));
        chk("t2_data",    64'(bus.rf_write_data), 64'(32'h7777));
        chk("t2_cnt0",    64'(bus.fifo_count),    64'(0));

        // starvation
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h9999;
        step();
        bus.lsu_valid = 1'b0;
        repeat (4) step();
        chk("t3_forced",  64'(bus.alu_ready),    64'(0));
        step();
        chk("t3_reg9",    64'(bus.rf_write_reg), 64'(9));
        chk("t3_resume",  64'(bus.alu_ready),    64'(1));
        step();
        chk("t3_alu_reg", 64'(bus.rf_write_reg), 64'(1));

        // FIFO full with ALU saturating
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd20; bus.lsu_data = 32'h20;
        step();
        bus.lsu_rd = 5'd21; bus.lsu_data = 32'h21;
        step();
        bus.lsu_rd = 5'd22; bus.lsu_data = 32'h22;
        chk("t4_full_cnt", 64'(bus.fifo_count), 64'(2));
        chk("t4_not_rdy",  64'(bus.lsu_ready),  64'(0));
        for (int i = 0; i < 20 && !bus.lsu_ready; i++) step();
        chk("t4_release", 64'(bus.lsu_ready), 64'(1));
        step();
        bus.lsu_valid = 1'b0; bus.alu_valid = 1'b0;
        repeat (4) step();
        chk("t4_drained", 64'(bus.fifo_count), 64'(0));

        // x0 beat
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hABCD;
        step();
        bus.lsu_valid = 1'b0;
        step();
        chk("t5_x0_we",  64'(bus.rf_reg_write), 64'(0));
        chk("t5_x0_reg", 64'(bus.rf_write_reg), 64'(0));
        chk("t5_x0_cnt", 64'(bus.fifo_count),   64'(0));

        // pending-write lookup
        bus.chk_reg   = 5'd12;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h4;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'hC0C0;
        step();
        bus.lsu_valid = 1'b0;
        #1;
        chk("t5_pend_buf", 64'(bus.chk_pending), 64'(1));
        bus.alu_valid = 1'b0;
        step();
        chk("t5_pend_wr",  64'(bus.chk_pending),  64'(1));
        chk("t5_wr12",     64'(bus.rf_write_reg), 64'(12));
        step();
        chk("t5_pend_clr", 64'(bus.chk_pending), 64'(0));
        bus.chk_reg = 5'd0;
        #1;
        chk("t5_x0_chk", 64'(bus.chk_pending), 64'(0));

        // reset mid-flight
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd14; bus.lsu_data = 32'hE;
        step();
        bus.lsu_rd = 5'd15; bus.lsu_data = 32'hF;
        step();
        bus.lsu_valid = 1'b0;
        bus.chk_reg = 5'd14;
        chk("t6_cnt2", 64'(bus.fifo_count), 64'(2));
        #1 reset_n = 1'b0;
        #1;
        chk("t6_cnt0",  64'(bus.fifo_count),   64'(0));
        chk("t6_we0",   64'(bus.rf_reg_write), 64'(0));
        chk("t6_pend0", 64'(bus.chk_pending),  64'(0));
        chk("t6_alu_r", 64'(bus.alu_ready),    64'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_clear();
        bus.alu_valid = 1'b0;
        repeat (4) step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.alu_valid = 1'($urandom_range(0, 3) != 0);
            bus.alu_rd    = 5'($urandom_range(0, 7));
            bus.alu_data  = $urandom();
            bus.lsu_valid = 1'($urandom_range(0, 1));
            bus.lsu_rd    = 5'($urandom_range(0, 7));
            bus.lsu_data  = $urandom();
            bus.chk_reg   = 5'($urandom_range(0, 7));
            step();
        end
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
